// File: rtl/touch_scan_ctrl.sv
// Resistive-touch ADC scan sequencer (ADS7843-style serial interface).
// While the pen is down it runs an X conversion followed by a Y conversion,
// publishes the pair with a one-cycle strobe, then idles for a fixed gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for ena and synchronised pen-down
// CS_SETUP | chip select low, serial clock low, command MSB on touch_din
// SHIFT    | 24 serial clock periods: 8 command bits out, 12 result bits in
// CS_HOLD  | chip select high between frames; result latched at the end
// GAP      | idle spacing after a published pair
module touch_scan_ctrl #(
    parameter int         CLK_DIV    = 50,
    parameter int         SAMPLE_GAP = 100000,
    parameter logic [7:0] CMD_X      = 8'hD0,
    parameter logic [7:0] CMD_Y      = 8'h90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        pen_irq_n,
    input  logic        touch_dout,
    output logic        touch_cs_n,
    output logic        touch_clk,
    output logic        touch_din,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        pos_valid,
    output logic        busy
);

    localparam int CNT_MAX = (SAMPLE_GAP > CLK_DIV) ? SAMPLE_GAP : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(SAMPLE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pen_meta;
    logic             pen_sync;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             phase_hi;
    logic [4:0]       bit_idx;
    logic             last_bit;
    logic             capture_slot;
    logic             sel;
    logic [11:0]      shreg;
    logic [11:0]      x_hold;
    logic [7:0]       cmd;
    logic [2:0]       din_idx;

    assign cnt_zero     = (cnt == '0);
    assign last_bit     = (bit_idx == 5'd23);
    // bit 8 is the ADC busy slot and 21..23 are trailing zeros; only 9..20 carry data
    assign capture_slot = (bit_idx >= 5'd9) && (bit_idx <= 5'd20);
    assign cmd          = sel ? CMD_Y : CMD_X;

    // Two-flop synchroniser for the asynchronous pen-down line (idles as pen-up)
    always_ff @(posedge clk) begin
        if (!rst) begin
            pen_meta <= 1'b1;
            pen_sync <= 1'b1;
        end else begin
            pen_meta <= pen_irq_n;
            pen_sync <= pen_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; pen and enable only matter in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ena && !pen_sync) state_nxt = CS_SETUP;
            CS_SETUP: if (cnt_zero) state_nxt = SHIFT;
            SHIFT:    if (cnt_zero && phase_hi && last_bit) state_nxt = CS_HOLD;
            CS_HOLD:  if (cnt_zero) state_nxt = sel ? GAP : CS_SETUP;
            GAP:      if (cnt_zero) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Timer, serial phase/bit tracking, result capture and publication
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            phase_hi  <= 1'b0;
            bit_idx   <= '0;
            sel       <= 1'b0;
            shreg     <= '0;
            x_hold    <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            pos_valid <= 1'b0;
        end else begin
            pos_valid <= 1'b0;

            if (state_nxt != state) begin
                case (state_nxt)
                    CS_SETUP, SHIFT, CS_HOLD: cnt <= DIV_LOAD;
                    GAP:                      cnt <= GAP_LOAD;
                    default:                  cnt <= '0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end else if (state == SHIFT) begin
                cnt <= DIV_LOAD;
            end

            case (state)
                IDLE: begin
                    if (state_nxt == CS_SETUP) sel <= 1'b0;
                end
                CS_SETUP: begin
                    phase_hi <= 1'b0;
                    bit_idx  <= '0;
                    shreg    <= '0;
                end
                SHIFT: begin
                    if (cnt_zero) begin
                        if (!phase_hi) begin
                            // this edge raises touch_clk: sample the ADC here
                            phase_hi <= 1'b1;
                            if (capture_slot) shreg <= {shreg[10:0], touch_dout};
                        end else begin
                            phase_hi <= 1'b0;
                            bit_idx  <= bit_idx + 5'd1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (cnt_zero) begin
                        if (!sel) begin
                            x_hold <= shreg;
                            sel    <= 1'b1;
                        end else begin
                            x_pos     <= x_hold;
                            y_pos     <= shreg;
                            pos_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Serial interface outputs decoded from state; touch_din only moves with touch_clk falling
    always_comb begin
        touch_cs_n = 1'b1;
        touch_clk  = 1'b0;
        touch_din  = 1'b0;
        din_idx    = 3'd7 - bit_idx[2:0];
        busy       = (state != IDLE);
        case (state)
            CS_SETUP: begin
                touch_cs_n = 1'b0;
                touch_din  = cmd[7];
            end
            SHIFT: begin
                touch_cs_n = 1'b0;
                touch_clk  = phase_hi;
                if (bit_idx < 5'd8) touch_din = cmd[din_idx];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Directed bench for touch_scan_ctrl with CLK_DIV=2, SAMPLE_GAP=4.
// A cycle-level ADC model decodes the command byte and returns fixed X/Y codes.
module tb_touch_scan_ctrl;

    localparam int NF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        pen_irq_n = 1'b1;
    logic        touch_dout = 1'b0;
    logic        touch_cs_n;
    logic        touch_clk;
    logic        touch_din;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        pos_valid;
    logic        busy;

    logic [11:0] adc_x = 12'h000;
    logic [11:0] adc_y = 12'h000;

    int n_chk  = 0;
    int n_pass = 0;

    touch_scan_ctrl #(
        .CLK_DIV    (2),
        .SAMPLE_GAP (4),
        .CMD_X      (8'hD0),
        .CMD_Y      (8'h90)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pen_irq_n  (pen_irq_n),
        .touch_dout (touch_dout),
        .touch_cs_n (touch_cs_n),
        .touch_clk  (touch_clk),
        .touch_din  (touch_din),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .pos_valid  (pos_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // monitor / ADC model state
    int          cyc = 0;
    logic        prev_cs = 1'b1;
    logic        prev_tclk = 1'b0;
    logic        prev_din = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_pv = 1'b0;
    int          cs_high_run = 0;
    int          tclk_run = 0;
    int          cur_rises = 0;
    int          slot = 0;
    logic [7:0]  cmd_cap = 8'h00;
    logic [11:0] conv_data = 12'h000;
    int          n_fall = 0;
    int          n_end = 0;
    int          n_busy = 0;
    int          n_pv = 0;
    int          hp_bad = 0;
    int          din_viol = 0;
    int          pv_wide = 0;
    int          cs_idle_viol = 0;
    int          tclk_cs_viol = 0;
    int          cs_gap [NF];
    logic [7:0]  frame_cmd [NF];
    int          frame_rises [NF];
    int          busy_rise [NF];
    int          pv_cyc [NF];
    logic [11:0] pv_x [NF];
    logic [11:0] pv_y [NF];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Bus monitor plus ADC model, all sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !touch_cs_n) begin
            if (n_fall < NF) cs_gap[n_fall] = cs_high_run;
            n_fall++;
            cur_rises = 0;
            cmd_cap = 8'h00;
            conv_data = 12'h000;
            slot = 0;
            touch_dout = 1'b0;
        end
        if (!prev_cs && touch_cs_n) begin
            if (n_end < NF) begin
                frame_cmd[n_end] = cmd_cap;
                frame_rises[n_end] = cur_rises;
            end
            n_end++;
        end
        if (touch_cs_n) cs_high_run++;
        else cs_high_run = 0;

        if (!prev_tclk && touch_clk) begin
            if (rst && cur_rises > 0 && tclk_run != 2) hp_bad++;
            if (cur_rises < 8) cmd_cap = {cmd_cap[6:0], touch_din};
            cur_rises++;
            if (cur_rises == 8)
                conv_data = (cmd_cap[6:4] == 3'b101) ? adc_x :
                            (cmd_cap[6:4] == 3'b001) ? adc_y : 12'h000;
            tclk_run = 1;
        end else if (prev_tclk && !touch_clk) begin
            if (rst && tclk_run != 2) hp_bad++;
            slot++;
            touch_dout = (slot >= 9 && slot <= 20) ? conv_data[4'(20 - slot)] : 1'b0;
            tclk_run = 1;
        end else begin
            tclk_run++;
        end

        if (touch_clk && touch_din !== prev_din) din_viol++;
        if (!touch_cs_n && !busy) cs_idle_viol++;
        if (touch_clk && touch_cs_n) tclk_cs_viol++;
        if (!prev_busy && busy) begin
            if (n_busy < NF) busy_rise[n_busy] = cyc;
            n_busy++;
        end
        if (pos_valid) begin
            if (prev_pv) pv_wide++;
            if (n_pv < NF) begin
                pv_cyc[n_pv] = cyc;
                pv_x[n_pv] = x_pos;
                pv_y[n_pv] = y_pos;
            end
            n_pv++;
        end
        prev_cs = touch_cs_n;
        prev_tclk = touch_clk;
        prev_din = touch_din;
        prev_busy = busy;
        prev_pv = pos_valid;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pv(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_pv < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_pv >= target), 32'd1);
    endtask

    task automatic wait_frame_rises(input int falls, input int rises, input int budget, input string tag);
        int k;
        k = 0;
        while (!(n_fall >= falls && cur_rises >= rises) && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_fall >= falls && cur_rises >= rises), 32'd1);
    endtask

    initial begin
        // reset, pen up
        tick(3);
        check("rst_cs_n", 32'(touch_cs_n), 32'd1);
        check("rst_tclk", 32'(touch_clk), 32'd0);
        check("rst_din", 32'(touch_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pv", 32'(pos_valid), 32'd0);
        check("rst_xy", {8'h00, x_pos, y_pos}, 32'd0);
        rst = 1'b1;
        tick(500);
        check("idle_no_busy", 32'(n_busy), 32'd0);
        check("idle_no_frame", 32'(n_fall), 32'd0);

        // first pair
        adc_x = 12'hA5C;
        adc_y = 12'h3F1;
        pen_irq_n = 1'b0;
        wait_pv(1, 400, "pair1_reach");
        adc_x = 12'h000;
        adc_y = 12'hFFF;
        check("pair1_x", 32'(pv_x[0]), 32'hA5C);
        check("pair1_y", 32'(pv_y[0]), 32'h3F1);
        check("pair1_latency", 32'(pv_cyc[0] - busy_rise[0]), 32'd200);
        check("frame0_cmd", 32'(frame_cmd[0]), 32'hD0);
        check("frame1_cmd", 32'(frame_cmd[1]), 32'h90);
        check("frame0_rises", 32'(frame_rises[0]), 32'd24);
        check("frame1_rises", 32'(frame_rises[1]), 32'd24);
        check("xy_cs_gap", 32'(cs_gap[1]), 32'd2);

        // second pair, pen held: extremes of the code range
        wait_pv(2, 400, "pair2_reach");
        adc_x = 12'h123;
        adc_y = 12'h456;
        check("pair2_spacing", 32'(pv_cyc[1] - pv_cyc[0]), 32'd205);
        check("pair2_x", 32'(pv_x[1]), 32'h000);
        check("pair2_y", 32'(pv_y[1]), 32'hFFF);
        check("pair2_hold_x", 32'(x_pos), 32'h000);

        // third pair: release pen during the Y frame
        wait_frame_rises(6, 0, 400, "pair3_yframe_reach");
        tick(10);
        pen_irq_n = 1'b1;
        wait_pv(3, 400, "pair3_reach");
        check("pair3_x", 32'(pv_x[2]), 32'h123);
        check("pair3_y", 32'(pv_y[2]), 32'h456);
        tick(100);
        check("released_busy", 32'(busy), 32'd0);
        check("released_scans", 32'(n_busy), 32'd3);
        check("released_hold_y", 32'(y_pos), 32'h456);

        // enable low blocks a scan even with pen down
        ena = 1'b0;
        pen_irq_n = 1'b0;
        tick(100);
        check("ena_low_scans", 32'(n_busy), 32'd3);

        // reset in the middle of the X frame at bit 12
        adc_x = 12'h7E2;
        adc_y = 12'h09B;
        ena = 1'b1;
        wait_frame_rises(7, 13, 400, "abort_point_reach");
        rst = 1'b0;
        tick(1);
        check("abort_cs_n", 32'(touch_cs_n), 32'd1);
        check("abort_tclk", 32'(touch_clk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pv_count", 32'(n_pv), 32'd3);
        check("abort_xy_clear", {8'h00, x_pos, y_pos}, 32'd0);
        tick(2);
        rst = 1'b1;
        wait_pv(4, 400, "pair4_reach");
        check("pair4_x", 32'(pv_x[3]), 32'h7E2);
        check("pair4_y", 32'(pv_y[3]), 32'h09B);
        check("pair4_latency", 32'(pv_cyc[3] - busy_rise[4]), 32'd200);
        check("frame7_cmd", 32'(frame_cmd[7]), 32'hD0);
        check("frame8_cmd", 32'(frame_cmd[8]), 32'h90);
        check("frame8_rises", 32'(frame_rises[8]), 32'd24);

        pen_irq_n = 1'b1;
        tick(50);
        check("half_period_viol", 32'(hp_bad), 32'd0);
        check("din_stable_viol", 32'(din_viol), 32'd0);
        check("pv_width_viol", 32'(pv_wide), 32'd0);
        check("cs_low_idle_viol", 32'(cs_idle_viol), 32'd0);
        check("tclk_cs_high_viol", 32'(tclk_cs_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/touch_scan_ctrl.md
Name: touch_scan_ctrl

Overview:
Sequencer for the resistive-touch ADC serial interface (ADS7843-style, 12-bit). When the pen is down, it frames chip-select, generates touch_clk, and shifts out the 8-bit command. It then captures the 12-bit result MSB-first, alternating X then Y conversions. It publishes a coordinate pair with a one-cycle valid strobe to the display/cursor logic, then waits a programmable gap before rescanning.

Parameters:
CLK_DIV, 50, clk cycles per touch_clk half-period (≥2)
SAMPLE_GAP, 100000, idle clk cycles after each published pair before the next scan (≥1)
CMD_X, 8'hD0, command byte for X conversion (S=1, A=101, 12-bit, differential, PD=00)
CMD_Y, 8'h90, command byte for Y conversion (S=1, A=001, 12-bit, differential, PD=00)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
ena  in  1  scan enable; sampled only in IDLE
pen_irq_n  in  1  asynchronous pen-down from ADC, active-low; 2-FF synchronised internally
touch_dout  in  1  serial data from ADC
touch_cs_n  out  1  ADC chip select, active-low
touch_clk  out  1  ADC serial clock
touch_din  out  1  serial command to ADC
x_pos  out  12  last captured X
y_pos  out  12  last captured Y
pos_valid  out  1  one-cycle strobe: x_pos/y_pos updated
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clock is clk; rst synchronous, active-low): state=IDLE, touch_cs_n=1, touch_clk=0, touch_din=0, x_pos=y_pos=0, pos_valid=0, busy=0, all counters and shift registers cleared. Reset mid-frame aborts immediately; no partial result is published.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP. An internal flag sel selects X (0) or Y (1).
- IDLE:
  - If ena=1 and synchronised pen=0: drive touch_cs_n=0, sel=0, go to CS_SETUP.
  - Otherwise remain in IDLE.
- CS_SETUP:
  - touch_cs_n=0 and touch_clk=0 for CLK_DIV cycles.
  - touch_din holds bit 7 of the current command.
  - Then go to SHIFT with bit index b=0.
- SHIFT: 24 touch_clk periods, b=0..23. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - touch_din changes only on the clk edge that drives touch_clk 1→0 (and at CS_SETUP entry).
  - For b=0..7, touch_din = cmd[7-b]. For b≥8, touch_din=0.
  - touch_dout is sampled on the clk edge that drives touch_clk 0→1.
  - For b=9..20, the sampled bit goes to result bit [20-b] (MSB first). b=8 is the BUSY slot; b=21..23 are trailing zeros. Both are ignored.
  - After the high phase of b=23, touch_clk returns to 0; go to CS_HOLD.
- CS_HOLD:
  - touch_clk=0 and touch_cs_n=1 for CLK_DIV cycles.
  - If sel=0: latch the result into an internal X holding register, set sel=1, touch_cs_n=0, go to CS_SETUP.
  - If sel=1: load x_pos←X holding register and y_pos←result in the same cycle, assert pos_valid for exactly that one cycle, go to GAP.
- GAP: count SAMPLE_GAP cycles with touch_cs_n=1, then go to IDLE.
- Conversion timing:
  - One conversion = CLK_DIV + 48·CLK_DIV + CLK_DIV = 50·CLK_DIV cycles.
  - pos_valid rises 100·CLK_DIV cycles after leaving IDLE.
- Pen and enable changes:
  - pen_irq_n and ena are ignored outside IDLE; a started X/Y pair always completes and is published.
  - Pen release during GAP means no new scan starts.
- x_pos and y_pos hold their values between pos_valid strobes; they are never partially updated.
- touch_cs_n is never low while in IDLE or GAP. touch_clk is never high outside SHIFT.

Test Plan:
- Reset with CLK_DIV=2, SAMPLE_GAP=4, pen_irq_n=1, ena=1 → cs_n=1, touch_clk=0, busy=0, x_pos=y_pos=0; no activity for 500 cycles.
- Pen down; ADC model returns X=12'hA5C, Y=12'h3F1 in slots b=9..20 → on touch_din observe X frame 8'hD0 and Y frame 8'h90, MSB first. pos_valid pulses once, 200 cycles after leaving IDLE, with x_pos=12'hA5C, y_pos=12'h3F1.
- Check touch_clk edges → 24 rising edges per frame; each half-period exactly 2 clk; touch_din stable across every rising edge; cs_n high for 2 cycles between X and Y frames.
- Pen held down → second pos_valid arrives 200+4+1 cycles after the first (GAP plus IDLE re-entry). Values 12'h000 and 12'hFFF are captured correctly.
- Release pen during Y frame → pair still published. After GAP, block stays in IDLE with busy=0.
- Assert rst=0 during the X frame at b=12 → next cycle: cs_n=1, touch_clk=0, no pos_valid. After release with pen down, a fresh full pair is produced.
